// File: rtl/fp_div_seq.sv
// ---------------------------------------------------------------------------
// fp_div_seq : sequential IEEE-style floating-point divider (a / b).
//
// Operands are {sign, exponent, mantissa} with a hidden leading one. Denormal
// inputs are flushed to zero. The mantissa quotient comes from a restoring
// radix-2 divider (one bit per cycle), is normalised once and truncated.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : request, accepted only while busy is low
//   a, b       : dividend / divisor, captured on the accepting edge
//   busy       : high from the accepting edge until the done cycle
//   done       : one-cycle pulse, result and flags valid
//   result     : quotient, held until the next done
//   overflow   : result saturated to infinity
//   underflow  : result flushed to zero
//   exception  : invalid operand (NaN/Inf input or zero divisor), result qNaN
// ---------------------------------------------------------------------------
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   exception
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EW   = EXP_W + 2;              // signed exponent, no wrap
  localparam int CW   = $clog2(MAN_W + 3);

  localparam logic [W-1:0]    QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EW-1:0]   EXP_ONE  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-2:0]   EXP_MAX  = (EW-1)'((1 << EXP_W) - 1);
  localparam logic [CW-1:0]   LAST_BIT = CW'(MAN_W + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    DIVIDE = 3'd2,
    NORM   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state_r, next_state_s;

  logic [W-1:0]     a_r, b_r;
  logic             sign_r;
  logic [EW-1:0]    exp_r;
  logic [MAN_W:0]   mb_r;
  logic [MAN_W+1:0] rem_r;
  logic [MAN_W+1:0] q_r;
  logic [CW-1:0]    cnt_r;
  logic             hold_r;
  logic             busy_s, done_s;

  // operand decode
  logic [EXP_W-1:0] a_exp_s, b_exp_s;
  logic             a_zero_s, b_zero_s, a_max_s, b_max_s;
  logic             nan_s, special_s, sign_s, accept_s;

  assign a_exp_s   = a_r[W-2:MAN_W];
  assign b_exp_s   = b_r[W-2:MAN_W];
  assign a_zero_s  = (a_exp_s == {EXP_W{1'b0}});
  assign b_zero_s  = (b_exp_s == {EXP_W{1'b0}});
  assign a_max_s   = &a_exp_s;
  assign b_max_s   = &b_exp_s;
  assign nan_s     = a_max_s | b_max_s | b_zero_s;
  assign special_s = nan_s | a_zero_s;
  assign sign_s    = a_r[W-1] ^ b_r[W-1];
  // IDLE and DONE are the only non-busy states
  assign accept_s  = start && ((state_r == IDLE) || (state_r == DONE));

  // one restoring step: trial subtract, keep on no borrow, then shift
  logic [MAN_W+2:0] diff_s;
  logic             ge_s;
  logic [MAN_W+1:0] rem_keep_s;

  assign diff_s     = {1'b0, rem_r} - {2'b00, mb_r};
  assign ge_s       = ~diff_s[MAN_W+2];
  assign rem_keep_s = ge_s ? diff_s[MAN_W+1:0] : rem_r;

  // normalisation: quotient lies in [0.5, 2), at most one left shift
  logic [EW-1:0]    fexp_s;
  logic [MAN_W-1:0] fman_s;
  logic             ovf_s, unf_s;

  assign fexp_s = q_r[MAN_W+1] ? exp_r : (exp_r - EXP_ONE);
  assign fman_s = q_r[MAN_W+1] ? q_r[MAN_W:1] : q_r[MAN_W-1:0];
  assign ovf_s  = ~fexp_s[EW-1] && (fexp_s[EW-2:0] >= EXP_MAX);
  assign unf_s  = fexp_s[EW-1] || (fexp_s == {EW{1'b0}});

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_state_s;
  end

  // next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:   if (accept_s) next_state_s = UNPACK; else next_state_s = IDLE;
      // special operands commit on a second UNPACK cycle, mirroring NORM
      UNPACK: begin
        if (!special_s)  next_state_s = DIVIDE;
        else if (hold_r) next_state_s = DONE;
        else             next_state_s = UNPACK;
      end
      DIVIDE: if (cnt_r == LAST_BIT) next_state_s = NORM; else next_state_s = DIVIDE;
      NORM:   next_state_s = DONE;
      DONE:   if (accept_s) next_state_s = UNPACK; else next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // output decode from the upcoming state so busy/done can be registered
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (next_state_s)
      UNPACK, DIVIDE, NORM: busy_s = 1'b1;
      DONE:                 done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_s;
      done <= done_s;
    end
  end

  // datapath: operand capture, unpack, divide iterations, result commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
      sign_r    <= 1'b0;
      exp_r     <= {EW{1'b0}};
      mb_r      <= {(MAN_W+1){1'b0}};
      rem_r     <= {(MAN_W+2){1'b0}};
      q_r       <= {(MAN_W+2){1'b0}};
      cnt_r     <= {CW{1'b0}};
      hold_r    <= 1'b0;
      result    <= {W{1'b0}};
      overflow  <= 1'b0;
      underflow <= 1'b0;
      exception <= 1'b0;
    end else begin
      if (accept_s) begin
        a_r       <= a;
        b_r       <= b;
        hold_r    <= 1'b0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
        exception <= 1'b0;
      end
      case (state_r)
        UNPACK: begin
          sign_r <= sign_s;
          exp_r  <= {2'b00, a_exp_s} - {2'b00, b_exp_s} + EW'(BIAS);
          mb_r   <= {1'b1, b_r[MAN_W-1:0]};
          rem_r  <= {1'b0, 1'b1, a_r[MAN_W-1:0]};
          q_r    <= {(MAN_W+2){1'b0}};
          cnt_r  <= {CW{1'b0}};
          if (special_s) begin
            hold_r <= 1'b1;
            if (hold_r) begin
              result    <= nan_s ? QNAN : {sign_s, {(W-1){1'b0}}};
              exception <= nan_s;
            end
          end
        end
        DIVIDE: begin
          q_r   <= {q_r[MAN_W:0], ge_s};
          rem_r <= {rem_keep_s[MAN_W:0], 1'b0};
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        NORM: begin
          if (ovf_s) begin
            result   <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            overflow <= 1'b1;
          end else if (unf_s) begin
            result    <= {sign_r, {(W-1){1'b0}}};
            underflow <= 1'b1;
          end else begin
            result <= {sign_r, fexp_s[EXP_W-1:0], fman_s};
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule
